// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - byte-wide command RAM fed by SPI slave words, read data returned as tx_data
module spi_ram #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] din,
   input  logic       rx_valid,
   output logic [7:0] dout,
   output logic       tx_valid
);

   typedef enum logic [1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } cmd_t;

   localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

   logic [7:0]           mem [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   cmd_t                 cmd;

   assign cmd = cmd_t'(din[9:8]);

   // Memory is a register array so the whole thing can be cleared in the reset cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
         wr_addr  <= '0;
         rd_addr  <= '0;
         dout     <= 8'h00;
         tx_valid <= 1'b0;
      end else if (rx_valid) begin
         case (cmd)
            WR_ADDR: begin
               wr_addr  <= din[ADDR_SIZE-1:0];
               tx_valid <= 1'b0;
            end
            WR_DATA: begin
               mem[wr_addr] <= din[7:0];
               if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_ONE;
               tx_valid <= 1'b0;
            end
            RD_ADDR: begin
               rd_addr  <= din[ADDR_SIZE-1:0];
               tx_valid <= 1'b0;
            end
            RD_DATA: begin
               dout     <= mem[rd_addr];
               tx_valid <= 1'b1;
               if (AUTO_INC != 0) rd_addr <= rd_addr + ADDR_ONE;
            end
            default: tx_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram.sv
// tb/tb_spi_ram.sv - vector table, hand sequences and random traffic against a reference model
module tb_spi_ram;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] din = 10'h000;
   logic       rx_valid = 1'b0;
   logic [7:0] dout0, dout1;
   logic       txv0, txv1;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_ram (
      .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout0), .tx_valid(txv0));

   spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_ram_inc (
      .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout1), .tx_valid(txv1));

   // Reference: index 0 models AUTO_INC=0, index 1 models AUTO_INC=1.
   logic [7:0] m_mem [2][256];
   logic [7:0] m_wr [2];
   logic [7:0] m_rd [2];
   logic [7:0] m_dout [2];
   logic       m_txv [2];

   task automatic model_step(input logic r, input logic v, input logic [9:0] d);
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            for (int a = 0; a < 256; a++) m_mem[k][a] = 8'h00;
            m_wr[k] = 8'h00; m_rd[k] = 8'h00; m_dout[k] = 8'h00; m_txv[k] = 1'b0;
         end else if (v) begin
            if (d[9:8] == 2'd0) m_wr[k] = d[7:0];
            if (d[9:8] == 2'd1) begin
               m_mem[k][m_wr[k]] = d[7:0];
               m_wr[k] = m_wr[k] + 8'(k);
            end
            if (d[9:8] == 2'd2) m_rd[k] = d[7:0];
            if (d[9:8] == 2'd3) begin
               m_dout[k] = m_mem[k][m_rd[k]];
               m_rd[k] = m_rd[k] + 8'(k);
            end
            m_txv[k] = (d[9:8] == 2'd3);
         end
      end
   endtask

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input logic r, input logic v, input logic [9:0] d, input int idx);
      rst = r; rx_valid = v; din = d;
      @(posedge clk);
      model_step(r, v, d);
      @(negedge clk);
      check("model_dout0", idx, dout0, m_dout[0]);
      check("model_txv0", idx, {7'd0, txv0}, {7'd0, m_txv[0]});
      check("model_dout1", idx, dout1, m_dout[1]);
      check("model_txv1", idx, {7'd0, txv1}, {7'd0, m_txv[1]});
   endtask

   typedef struct {
      logic       r;
      logic       v;
      logic [9:0] d;
      logic [7:0] ed;
      logic       et;
   } vec_t;

   vec_t tbl [21];

   logic [9:0] basic_seq [5];

   initial begin
      // Expected values below are for the AUTO_INC=0 instance.
      tbl[0]  = '{1'b1, 1'b1, 10'h1AA, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 10'h1AA, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 10'h200, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 10'h300, 8'h00, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 10'h03C, 8'h00, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 10'h1A5, 8'h00, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 10'h23C, 8'h00, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 10'h300, 8'hA5, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 10'h000, 8'hA5, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 10'h010, 8'hA5, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 10'h220, 8'hA5, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 10'h111, 8'hA5, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 10'h300, 8'h00, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 10'h210, 8'h00, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 10'h300, 8'h11, 1'b1};
      tbl[15] = '{1'b0, 1'b1, 10'h005, 8'h11, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 10'h177, 8'h11, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 10'h000, 8'h00, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 10'h205, 8'h00, 1'b0};
      tbl[19] = '{1'b0, 1'b1, 10'h300, 8'h00, 1'b1};
      tbl[20] = '{1'b0, 1'b0, 10'h300, 8'h00, 1'b1};

      for (int i = 0; i < 21; i++) begin
         apply(tbl[i].r, tbl[i].v, tbl[i].d, i);
         check("tbl_dout", i, dout0, tbl[i].ed);
         check("tbl_txv", i, {7'd0, txv0}, {7'd0, tbl[i].et});
      end

      // Auto-increment across the top of the address space.
      apply(1'b1, 1'b0, 10'h000, 100);
      apply(1'b0, 1'b1, 10'h0FE, 101);
      apply(1'b0, 1'b1, 10'h101, 102);
      apply(1'b0, 1'b1, 10'h102, 103);
      apply(1'b0, 1'b1, 10'h103, 104);
      apply(1'b0, 1'b1, 10'h2FE, 105);
      apply(1'b0, 1'b1, 10'h300, 106);
      check("inc_dout", 0, dout1, 8'h01);
      check("inc_txv", 0, {7'd0, txv1}, 8'h01);
      apply(1'b0, 1'b1, 10'h300, 107);
      check("inc_dout", 1, dout1, 8'h02);
      check("inc_txv", 1, {7'd0, txv1}, 8'h01);
      apply(1'b0, 1'b1, 10'h300, 108);
      check("inc_dout", 2, dout1, 8'h03);
      check("inc_txv", 2, {7'd0, txv1}, 8'h01);
      apply(1'b0, 1'b1, 10'h200, 109);
      apply(1'b0, 1'b1, 10'h300, 110);
      check("inc_wrap_loc0", 0, dout1, 8'h03);

      // Basic write/read with random idle gaps between commands.
      basic_seq[0] = 10'h03C; basic_seq[1] = 10'h1A5; basic_seq[2] = 10'h23C;
      basic_seq[3] = 10'h300; basic_seq[4] = 10'h000;
      apply(1'b1, 1'b0, 10'h000, 200);
      for (int i = 0; i < 5; i++) begin
         int gap = $urandom_range(0, 5);
         for (int g = 0; g < gap; g++) apply(1'b0, 1'b0, 10'($urandom), 210 + i);
         apply(1'b0, 1'b1, basic_seq[i], 220 + i);
         if (i == 3) begin
            for (int g = 0; g < gap; g++) apply(1'b0, 1'b0, 10'h000, 230);
            check("gap_rd_dout", 0, dout0, 8'hA5);
            check("gap_rd_txv", 0, {7'd0, txv0}, 8'h01);
         end
      end
      check("gap_wr_dout", 0, dout0, 8'hA5);
      check("gap_wr_txv", 0, {7'd0, txv0}, 8'h00);

      // Random traffic; addresses biased to a small window so reads hit prior writes.
      for (int i = 0; i < 400; i++) begin
         logic [9:0] d;
         d[9:8] = 2'($urandom);
         d[7:0] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
         apply($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, d, 1000 + i);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_ram.md
# spi_ram

Single-port, byte-wide command RAM that sits directly downstream of the SPI slave inside the SPI wrapper. It consumes the slave's 10-bit received words (`rx_data`/`rx_valid`), decodes the 2-bit command field, and maintains separate write- and read-address registers. Read results go back to the slave as `tx_data`/`tx_valid` for shifting out on MISO.

## Interface

Parameters:
- `MEM_DEPTH` = 256: number of byte locations.
- `ADDR_SIZE` = 8: address width; `MEM_DEPTH` == 2**`ADDR_SIZE`.
- `AUTO_INC` = 0: when 1, the address register increments after each data command.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous active-high reset.
- `din` input 10: command word from the SPI slave `rx_data`.
  - [9:8] = command.
  - [7:0] = address or data payload.
- `rx_valid` input 1: `din` valid this cycle.
- `dout` output 8: read data to the SPI slave `tx_data`.
- `tx_valid` output 1: `dout` holds valid read data.

## Operation

- A command is accepted on a rising edge when `rx_valid`=1 and `rst`=0. At most one command is accepted per cycle.
- Command decode on `din[9:8]`:
  - 00 WR_ADDR: `wr_addr` <= `din[7:0]`.
  - 01 WR_DATA: `mem[wr_addr]` <= `din[7:0]`. If `AUTO_INC`=1, `wr_addr` <= `wr_addr`+1.
  - 10 RD_ADDR: `rd_addr` <= `din[7:0]`.
  - 11 RD_DATA: `dout` <= `mem[rd_addr]`; `tx_valid` <= 1. If `AUTO_INC`=1, `rd_addr` <= `rd_addr`+1. `din[7:0]` is ignored.
- `tx_valid` is a level signal:
  - Set by RD_DATA.
  - Cleared by the next accepted command of any other type.
  - Stays 1 across back-to-back RD_DATA; `dout` updates each time.
- `dout` holds its last value until the next RD_DATA or reset.
- Address arithmetic is modulo `MEM_DEPTH`: increment from `MEM_DEPTH`-1 wraps to 0. No overflow flag.
- `wr_addr` and `rd_addr` are independent. A write never moves `rd_addr`, and vice versa.
- Reset:
  - `dout`=0, `tx_valid`=0, `wr_addr`=0, `rd_addr`=0.
  - All `mem` locations cleared to 0. Clear is single-cycle; the memory must be registers or a clearable array.
- Reset during a command: `rst` has priority over `rx_valid`. The command in that cycle is discarded and no memory write occurs.
- `rx_valid`=0: all state holds.

## Timing

- Accept on edge N → effect visible after edge N:
  - For WR_ADDR/WR_DATA/RD_ADDR, the register or memory update is visible in cycle N+1.
  - For RD_DATA, `dout` and `tx_valid` are valid in cycle N+1 (one-cycle read latency).
- WR_DATA at edge N to address A, then RD_DATA at edge N+1 with `rd_addr`=A → `dout` returns the new value. There is no read-during-write hazard because the commands land on different edges.
- Combinational paths from inputs to outputs: none. All outputs are registered.
- The SPI slave issues commands at most once per 10+ SPI bits, but the block must sustain one command per `clk` cycle.

## Test plan

- **Reset:** assert `rst` 2 cycles with `rx_valid`=1 and `din`=10'h1_AA.
  - Expect `dout`=0 and `tx_valid`=0.
  - Then send RD_ADDR 0x00 and RD_DATA → `dout`=0x00, confirming no write occurred.
- **Basic write/read:** WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA.
  - Expect `dout`=0xA5 and `tx_valid`=1 one cycle after RD_DATA.
  - A following WR_ADDR drops `tx_valid` to 0 while `dout` stays 0xA5.
- **Independent addresses:** WR_ADDR 0x10, RD_ADDR 0x20, WR_DATA 0x11.
  - RD_DATA → `dout`=0x00 (0x20 untouched).
  - RD_ADDR 0x10, RD_DATA → `dout`=0x11.
- **Auto-increment wrap (`AUTO_INC`=1):** WR_ADDR 0xFE, WR_DATA 0x01/0x02/0x03 back-to-back; then RD_ADDR 0xFE and RD_DATA ×3.
  - Expect `dout` sequence 0x01, 0x02, 0x03, with location 0x00 holding 0x03.
  - `tx_valid` stays 1 for all three read cycles.
- **Gaps and idles:** same sequence as basic write/read with `rx_valid`=0 for 0–5 random cycles between commands.
  - Identical results; state holds during idle.
- **Mid-sequence reset:** WR_ADDR 0x05, WR_DATA 0x77, then `rst` 1 cycle, then RD_ADDR 0x05, RD_DATA.
  - Expect `dout`=0x00 (memory cleared) and `tx_valid`=1.
